// File: rtl/phased_burst_gen_if.sv
// phased_burst_gen_if: configuration handshake, abort and transducer drive
// bundle between the command decoder (master) and the burst generator (slave).
interface phased_burst_gen_if #(
  parameter int N_CH    = 4,
  parameter int DLY_W   = 16,
  parameter int BURST_W = 8
) ();
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DLY_W-1:0]   cfg_delay;
  logic               cfg_dir;
  logic [BURST_W-1:0] cfg_burst;
  logic               stop;
  logic [N_CH-1:0]    tx;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_delay, cfg_dir, cfg_burst, stop,
    input  cfg_ready, tx, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_delay, cfg_dir, cfg_burst, stop,
    output cfg_ready, tx, busy, done, cfg_err
  );
endinterface

// File: rtl/phased_burst_gen.sv
// phased_burst_gen: drives N_CH transducer channels with phase-stepped square
// waves. A new configuration is expanded into per-channel offsets one channel
// per cycle into a shadow set, which goes live only on a period boundary.
module phased_burst_gen #(
  parameter int N_CH      = 4,
  parameter int PERIOD    = 10000,
  parameter int HIGH_TIME = 5000,
  parameter int DLY_W     = 16,
  parameter int BURST_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  phased_burst_gen_if.slave bus
);
  localparam int CNT_W = $clog2(PERIOD);
  localparam int IDX_W = $clog2(N_CH);

  localparam logic [CNT_W:0]   PERIOD_X  = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   HIGH_X    = (CNT_W+1)'(HIGH_TIME);
  localparam logic [CNT_W-1:0] LAST_PCNT = CNT_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Operating state and period timing
  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [BURST_W-1:0] pdone_q, pdone_d;

  // Live settings
  logic [CNT_W-1:0]   off_q [N_CH];
  logic [CNT_W-1:0]   off_d [N_CH];
  logic               dir_q, dir_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  // Pending settings and shadow offsets
  logic [CNT_W-1:0]   pend_delay_q, pend_delay_d;
  logic               pend_dir_q, pend_dir_d;
  logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
  logic [CNT_W-1:0]   sh_off_q [N_CH];
  logic [CNT_W-1:0]   sh_off_d [N_CH];
  logic               calc_busy_q, calc_busy_d;
  logic [IDX_W-1:0]   calc_idx_q, calc_idx_d;
  logic [CNT_W-1:0]   calc_acc_q, calc_acc_d;
  logic               shadow_rdy_q, shadow_rdy_d;

  // Registered outputs
  logic [N_CH-1:0]    tx_q, tx_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ready_q, cfg_ready_d;

  // Helpers
  logic               accept_s;
  logic               bad_delay_s;
  logic               wrap_s;
  logic [BURST_W-1:0] cnt_inc_s;
  logic [CNT_W:0]     sum_s;
  logic [CNT_W-1:0]   next_acc_s;
  logic [N_CH-1:0]    tx_calc_s;
  logic [CNT_W:0]     phase_s [N_CH];

  assign accept_s    = bus.cfg_valid & cfg_ready_q & ~bus.stop;
  assign bad_delay_s = (32'(bus.cfg_delay) >= 32'(PERIOD));
  assign wrap_s      = (state_q == ST_RUN) && (pcnt_q == LAST_PCNT);
  assign cnt_inc_s   = pdone_q + BURST_W'(1);

  // Next offset in the chain: one add, one conditional subtract of PERIOD.
  always_comb begin
    sum_s = {1'b0, calc_acc_q} + {1'b0, pend_delay_q};
    if (sum_s >= PERIOD_X) begin
      next_acc_s = CNT_W'(sum_s - PERIOD_X);
    end else begin
      next_acc_s = sum_s[CNT_W-1:0];
    end
  end

  // Per-channel phase within the period; dir=1 mirrors the offset order.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      if (dir_q) begin
        phase_s[k] = {1'b0, pcnt_q} - {1'b0, off_q[N_CH-1-k]};
      end else begin
        phase_s[k] = {1'b0, pcnt_q} - {1'b0, off_q[k]};
      end
      if (phase_s[k][CNT_W]) begin
        phase_s[k] = phase_s[k] + PERIOD_X;
      end else begin
        phase_s[k] = phase_s[k];
      end
      tx_calc_s[k] = (phase_s[k] < HIGH_X);
    end
  end

  // Next-state logic: calc engine, config acceptance, run/idle control, abort.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    pdone_d      = pdone_q;
    off_d        = off_q;
    dir_d        = dir_q;
    burst_d      = burst_q;
    pend_delay_d = pend_delay_q;
    pend_dir_d   = pend_dir_q;
    pend_burst_d = pend_burst_q;
    sh_off_d     = sh_off_q;
    calc_busy_d  = calc_busy_q;
    calc_idx_d   = calc_idx_q;
    calc_acc_d   = calc_acc_q;
    shadow_rdy_d = shadow_rdy_q;
    tx_d         = {N_CH{1'b0}};
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    // Offset expansion, one channel per cycle
    if (calc_busy_q) begin
      sh_off_d[calc_idx_q] = calc_acc_q;
      calc_acc_d           = next_acc_s;
      calc_idx_d           = calc_idx_q + IDX_W'(1);
      if (calc_idx_q == LAST_IDX) begin
        calc_busy_d  = 1'b0;
        shadow_rdy_d = 1'b1;
      end else begin
        calc_busy_d  = 1'b1;
      end
    end else begin
      calc_busy_d = 1'b0;
    end

    // A bad delay completes the handshake but leaves every setting untouched
    if (accept_s) begin
      if (bad_delay_s) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_delay_d = CNT_W'(bus.cfg_delay);
        pend_dir_d   = bus.cfg_dir;
        pend_burst_d = bus.cfg_burst;
        calc_busy_d  = 1'b1;
        calc_idx_d   = {IDX_W{1'b0}};
        calc_acc_d   = {CNT_W{1'b0}};
      end
    end else begin
      cfg_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        pcnt_d = {CNT_W{1'b0}};
        if (shadow_rdy_q) begin
          state_d      = ST_RUN;
          off_d        = sh_off_q;
          dir_d        = pend_dir_q;
          burst_d      = pend_burst_q;
          pdone_d      = {BURST_W{1'b0}};
          shadow_rdy_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        tx_d = tx_calc_s;
        if (wrap_s) begin
          pcnt_d = {CNT_W{1'b0}};
          if ((burst_q != {BURST_W{1'b0}}) && (cnt_inc_s == burst_q)) begin
            // Burst end wins over a waiting swap; the waiting set is dropped
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            tx_d         = {N_CH{1'b0}};
            pdone_d      = {BURST_W{1'b0}};
            shadow_rdy_d = shadow_rdy_q ? 1'b0 : shadow_rdy_d;
          end else if (shadow_rdy_q) begin
            off_d        = sh_off_q;
            dir_d        = pend_dir_q;
            burst_d      = pend_burst_q;
            pdone_d      = {BURST_W{1'b0}};
            shadow_rdy_d = 1'b0;
          end else begin
            pdone_d = cnt_inc_s;
          end
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pcnt_d  = {CNT_W{1'b0}};
      end
    endcase

    // Abort: back to idle, abandon any calc or waiting set, no done
    if (bus.stop) begin
      state_d      = ST_IDLE;
      pcnt_d       = {CNT_W{1'b0}};
      pdone_d      = {BURST_W{1'b0}};
      tx_d         = {N_CH{1'b0}};
      done_d       = 1'b0;
      calc_busy_d  = 1'b0;
      shadow_rdy_d = 1'b0;
    end else begin
      state_d = state_d;
    end

    cfg_ready_d = ~(calc_busy_d | shadow_rdy_d);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= {CNT_W{1'b0}};
      pdone_q      <= {BURST_W{1'b0}};
      dir_q        <= 1'b0;
      burst_q      <= {BURST_W{1'b0}};
      pend_delay_q <= {CNT_W{1'b0}};
      pend_dir_q   <= 1'b0;
      pend_burst_q <= {BURST_W{1'b0}};
      calc_busy_q  <= 1'b0;
      calc_idx_q   <= {IDX_W{1'b0}};
      calc_acc_q   <= {CNT_W{1'b0}};
      shadow_rdy_q <= 1'b0;
      tx_q         <= {N_CH{1'b0}};
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        off_q[k]    <= {CNT_W{1'b0}};
        sh_off_q[k] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      pdone_q      <= pdone_d;
      dir_q        <= dir_d;
      burst_q      <= burst_d;
      pend_delay_q <= pend_delay_d;
      pend_dir_q   <= pend_dir_d;
      pend_burst_q <= pend_burst_d;
      calc_busy_q  <= calc_busy_d;
      calc_idx_q   <= calc_idx_d;
      calc_acc_q   <= calc_acc_d;
      shadow_rdy_q <= shadow_rdy_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
      off_q        <= off_d;
      sh_off_q     <= sh_off_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.cfg_ready = cfg_ready_q;

endmodule
